// File: rtl/wb_ram_burst.sv
// wb_ram_burst: Wishbone B4 slave RAM, 32-bit word organised, with classic
// single-beat and incrementing (linear / wrap-4/8/16) burst support.
module wb_ram_burst #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dwbs_addr,
  input  logic [31:0] dwbs_dat_w,
  input  logic [3:0]  dwbs_sel,
  input  logic        dwbs_cyc,
  input  logic        dwbs_stb,
  input  logic        dwbs_we,
  input  logic [2:0]  dwbs_cti,
  input  logic [1:0]  dwbs_bte,
  output logic [31:0] dwbs_dat_r,
  output logic        dwbs_ack,
  output logic        dwbs_err
);

  localparam int unsigned WW    = ADDR_WIDTH - 2;
  localparam int unsigned DEPTH = 1 << WW;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SINGLE = 2'd1;
  localparam logic [1:0] S_BURST  = 2'd2;
  localparam logic [1:0] S_ERR    = 2'd3;

  localparam logic [2:0] CTI_INC = 3'b010;

  logic [1:0]    r_state;
  logic [WW-1:0] r_addr;
  logic [31:0]   r_dat_r;
  logic [31:0]   r_mem [DEPTH];

  logic          w_hit;
  logic          w_ack;
  logic          w_err;
  logic          w_we;
  logic [WW-1:0] w_idx;
  logic [WW-1:0] w_inc;
  logic [WW-1:0] w_mask;
  logic [WW-1:0] w_next;

  // Address decode: aligned word inside the window starting at BASE_ADDR
  always_comb begin
    w_hit = (dwbs_addr[31:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH]) &&
            (dwbs_addr[1:0] == 2'b00);
    w_idx = dwbs_addr[ADDR_WIDTH-1:2];
  end

  // Next beat address: only the bits under the wrap mask advance
  always_comb begin
    case (dwbs_bte)
      2'b01:   w_mask = WW'(32'h3);
      2'b10:   w_mask = WW'(32'h7);
      2'b11:   w_mask = WW'(32'hF);
      default: w_mask = '1;
    endcase
    w_inc  = r_addr + WW'(1);
    w_next = (r_addr & ~w_mask) | (w_inc & w_mask);
  end

  // Terminations: SINGLE/ERR are one-cycle states; burst beats follow stb.
  // Read data is prefetched into r_dat_r so a burst beat can ack the same
  // cycle the master presents it.
  always_comb begin
    w_ack      = (r_state == S_SINGLE) ||
                 ((r_state == S_BURST) && dwbs_cyc && dwbs_stb);
    w_err      = (r_state == S_ERR);
    w_we       = w_ack && dwbs_we && !rst;
    dwbs_ack   = w_ack;
    dwbs_err   = w_err;
    dwbs_dat_r = w_ack ? r_dat_r : '0;
  end

  // Control FSM, beat address and read-data prefetch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_dat_r <= '0;
    end else if (!dwbs_cyc) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (dwbs_stb) begin
            if (!w_hit) begin
              r_state <= S_ERR;
            end else begin
              r_addr  <= w_idx;
              r_dat_r <= r_mem[w_idx];
              r_state <= (dwbs_cti == CTI_INC) ? S_BURST : S_SINGLE;
            end
          end
        end
        S_BURST: begin
          if (dwbs_stb) begin
            if (dwbs_cti != CTI_INC) begin
              r_state <= S_IDLE;
            end else begin
              r_addr  <= w_next;
              r_dat_r <= r_mem[w_next];
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Byte-lane writes at the current beat address; memory is never reset
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (dwbs_sel[i]) begin
          r_mem[r_addr][8*i +: 8] <= dwbs_dat_w[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_ram_burst.sv
// tb_wb_ram_burst: table-driven classic accesses plus hand-written burst,
// wait-state and reset-abort sequences, checked through an expectation queue.
module tb_wb_ram_burst;

  localparam int unsigned AW    = 12;
  localparam int unsigned WORDS = 1 << (AW - 2);
  localparam logic [31:0] BASE  = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] dwbs_addr = '0;
  logic [31:0] dwbs_dat_w = '0;
  logic [3:0]  dwbs_sel = '0;
  logic        dwbs_cyc = 1'b0;
  logic        dwbs_stb = 1'b0;
  logic        dwbs_we = 1'b0;
  logic [2:0]  dwbs_cti = '0;
  logic [1:0]  dwbs_bte = '0;
  logic [31:0] dwbs_dat_r;
  logic        dwbs_ack;
  logic        dwbs_err;

  wb_ram_burst #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .rst        (rst),
    .dwbs_addr  (dwbs_addr),
    .dwbs_dat_w (dwbs_dat_w),
    .dwbs_sel   (dwbs_sel),
    .dwbs_cyc   (dwbs_cyc),
    .dwbs_stb   (dwbs_stb),
    .dwbs_we    (dwbs_we),
    .dwbs_cti   (dwbs_cti),
    .dwbs_bte   (dwbs_bte),
    .dwbs_dat_r (dwbs_dat_r),
    .dwbs_ack   (dwbs_ack),
    .dwbs_err   (dwbs_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ack;
    logic        err;
    logic [31:0] dat;
    logic        chk_dat;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdat;
    logic        exp_err;
    logic [31:0] exp_rd;
    string       name;
  } vec_t;

  exp_t        exp_q[$];
  vec_t        tbl[12];
  logic [31:0] model [WORDS];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Wait (bounded) for a termination, check its latency, then pop and compare
  task automatic wait_resp(input int unsigned exp_wait, input string name);
    int unsigned n = 0;
    exp_t e;
    do begin
      @(negedge clk);
      n++;
    end while (!(dwbs_ack || dwbs_err) && n < 8);
    chk({name, " latency"}, 32'(n), 32'(exp_wait));
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: response with empty queue", name);
    end else begin
      e = exp_q.pop_front();
      chk({name, " ack"}, 32'(dwbs_ack), 32'(e.ack));
      chk({name, " err"}, 32'(dwbs_err), 32'(e.err));
      if (e.chk_dat) chk({name, " dat"}, dwbs_dat_r, e.dat);
    end
  endtask

  task automatic wb_single(input logic [31:0] a, input logic we, input logic [3:0] sel,
                           input logic [31:0] wd, input logic exp_err,
                           input logic [31:0] exp_rd, input string name);
    exp_t e;
    e.ack = !exp_err;
    e.err = exp_err;
    e.dat = exp_err ? 32'h0 : exp_rd;
    e.chk_dat = exp_err || !we;
    exp_q.push_back(e);
    @(posedge clk); #1;
    dwbs_cyc = 1'b1; dwbs_stb = 1'b1; dwbs_we = we; dwbs_addr = a;
    dwbs_sel = sel; dwbs_dat_w = wd; dwbs_cti = 3'b000; dwbs_bte = 2'b00;
    wait_resp(2, name);
    @(posedge clk); #1;
    dwbs_cyc = 1'b0; dwbs_stb = 1'b0; dwbs_we = 1'b0;
    @(negedge clk);
    chk({name, " ack after"}, 32'(dwbs_ack), 32'h0);
    chk({name, " err after"}, 32'(dwbs_err), 32'h0);
  endtask

  function automatic int unsigned nxt(input int unsigned w, input logic [1:0] bte);
    int unsigned m;
    case (bte)
      2'b01:   m = 3;
      2'b10:   m = 7;
      2'b11:   m = 15;
      default: m = WORDS - 1;
    endcase
    return (w & ~m & (WORDS - 1)) | ((w + 1) & m);
  endfunction

  // Burst master: one beat per ack, optional 2-cycle stb-low stall after
  // stall_after beats have completed (0 = no stall).
  task automatic wb_burst(input int unsigned start, input logic [1:0] bte,
                          input int unsigned nb, input logic we,
                          input logic [31:0] wbase, input int unsigned stall_after,
                          input string name);
    int unsigned w = start;
    exp_t e;
    for (int unsigned k = 0; k < nb; k++) begin
      if (stall_after != 0 && k == stall_after) begin
        for (int unsigned s = 0; s < 2; s++) begin
          @(posedge clk); #1;
          dwbs_stb = 1'b0;
          @(negedge clk);
          chk({name, " stall ack"}, 32'(dwbs_ack), 32'h0);
        end
      end
      e.ack = 1'b1; e.err = 1'b0; e.chk_dat = !we; e.dat = model[w];
      exp_q.push_back(e);
      @(posedge clk); #1;
      dwbs_cyc = 1'b1; dwbs_stb = 1'b1; dwbs_we = we; dwbs_sel = 4'hF;
      dwbs_addr = BASE + 32'(w * 4); dwbs_dat_w = wbase + 32'(k);
      dwbs_bte = bte; dwbs_cti = (k == nb - 1) ? 3'b111 : 3'b010;
      if (we) model[w] = wbase + 32'(k);
      wait_resp((k == 0) ? 2 : 1, $sformatf("%s beat%0d", name, k));
      w = nxt(w, bte);
    end
    @(posedge clk); #1;
    dwbs_cyc = 1'b0; dwbs_stb = 1'b0; dwbs_we = 1'b0; dwbs_cti = 3'b000;
    @(negedge clk);
    chk({name, " ack after last"}, 32'(dwbs_ack), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{BASE + 32'h8,    1'b1, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0,         "wr8"};
    tbl[1]  = '{BASE + 32'h8,    1'b0, 4'hF, 32'h0,        1'b0, 32'hDEADBEEF,  "rd8"};
    tbl[2]  = '{BASE + 32'h10,   1'b1, 4'hF, 32'h11223344, 1'b0, 32'h0,         "wr10"};
    tbl[3]  = '{BASE + 32'h10,   1'b1, 4'h2, 32'h0000AB00, 1'b0, 32'h0,         "wr10 lane1"};
    tbl[4]  = '{BASE + 32'h10,   1'b0, 4'hF, 32'h0,        1'b0, 32'h1122AB44,  "rd10 merged"};
    tbl[5]  = '{BASE,            1'b1, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0,         "wr0"};
    tbl[6]  = '{BASE + 32'h1000, 1'b1, 4'hF, 32'h12345678, 1'b1, 32'h0,         "wr top err"};
    tbl[7]  = '{BASE + 32'h1,    1'b1, 4'hF, 32'h87654321, 1'b1, 32'h0,         "wr misalign err"};
    tbl[8]  = '{BASE + 32'h1000, 1'b0, 4'hF, 32'h0,        1'b1, 32'h0,         "rd top err"};
    tbl[9]  = '{BASE,            1'b0, 4'hF, 32'h0,        1'b0, 32'hCAFEF00D,  "rd0 unchanged"};
    tbl[10] = '{BASE - 32'h4,    1'b0, 4'hF, 32'h0,        1'b1, 32'h0,         "rd below err"};
    tbl[11] = '{BASE + 32'h8,    1'b0, 4'hF, 32'h0,        1'b0, 32'hDEADBEEF,  "rd8 again"};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset ack", 32'(dwbs_ack), 32'h0);
    chk("reset err", 32'(dwbs_err), 32'h0);
    chk("reset dat", dwbs_dat_r, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (tbl[i])
      wb_single(tbl[i].addr, tbl[i].we, tbl[i].sel, tbl[i].wdat,
                tbl[i].exp_err, tbl[i].exp_rd, tbl[i].name);

    // Preload mem[i] = i on the words the bursts touch
    for (int unsigned w = 0; w < 48; w++) begin
      model[w] = 32'(w);
      wb_single(BASE + 32'(w * 4), 1'b1, 4'hF, 32'(w), 1'b0, 32'h0, "preload");
    end
    for (int unsigned w = WORDS - 2; w < WORDS; w++) begin
      model[w] = 32'(w);
      wb_single(BASE + 32'(w * 4), 1'b1, 4'hF, 32'(w), 1'b0, 32'h0, "preload top");
    end

    wb_burst(6,  2'b01, 4, 1'b0, 32'h0, 0, "wrap4 rd");
    wb_burst(13, 2'b10, 5, 1'b0, 32'h0, 0, "wrap8 rd");
    wb_burst(30, 2'b11, 4, 1'b0, 32'h0, 0, "wrap16 rd");
    wb_burst(20, 2'b00, 5, 1'b0, 32'h0, 2, "linear stall rd");
    wb_burst(WORDS - 2, 2'b00, 4, 1'b0, 32'h0, 0, "linear top wrap rd");
    wb_burst(46, 2'b01, 4, 1'b1, 32'h5A00_0000, 0, "wrap4 wr");
    wb_burst(44, 2'b00, 4, 1'b0, 32'h0, 0, "wrap4 readback");

    // Reset during beat 2 of an 8-beat linear write burst at word 40
    for (int unsigned k = 0; k < 2; k++) begin
      exp_t e;
      e.ack = 1'b1; e.err = 1'b0; e.dat = 32'h0; e.chk_dat = 1'b0;
      exp_q.push_back(e);
      @(posedge clk); #1;
      dwbs_cyc = 1'b1; dwbs_stb = 1'b1; dwbs_we = 1'b1; dwbs_sel = 4'hF;
      dwbs_addr = BASE + 32'((40 + k) * 4); dwbs_dat_w = 32'hA0 + 32'(k);
      dwbs_bte = 2'b00; dwbs_cti = 3'b010;
      model[40 + k] = 32'hA0 + 32'(k);
      wait_resp((k == 0) ? 2 : 1, $sformatf("rst burst beat%0d", k));
    end
    @(posedge clk); #1;
    dwbs_addr = BASE + 32'(42 * 4); dwbs_dat_w = 32'hA2;
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst abort ack", 32'(dwbs_ack), 32'h0);
    chk("rst abort err", 32'(dwbs_err), 32'h0);
    chk("rst abort dat", dwbs_dat_r, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    dwbs_cyc = 1'b0; dwbs_stb = 1'b0; dwbs_we = 1'b0; dwbs_cti = 3'b000;
    @(negedge clk);
    chk("post rst ack", 32'(dwbs_ack), 32'h0);
    for (int unsigned w = 40; w < 44; w++)
      wb_single(BASE + 32'(w * 4), 1'b0, 4'hF, 32'h0, 1'b0, model[w], "rst readback");
    wb_single(BASE + 32'h10, 1'b0, 4'hF, 32'h0, 1'b0, model[4], "survives rst");

    chk("queue drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
